// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the processor control slice.
// Holds the multiply op encoding, the stall-controller states and the x0 index.
package proc_ctrl_pkg;

  typedef enum logic [1:0] {
    MUL_LO = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_ERR
  } mul_ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mul_result_sel.sv
// Combinational multiply-op decode: operand signedness and product half selection.
// Kept standalone so the decode stage can share the same op table.
module mul_result_sel
  import proc_ctrl_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [63:0] product,
  output logic        signed_a,
  output logic        signed_b,
  output logic [31:0] result
);

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    result   = product[63:32];
    case (mul_op_e'(op))
      MUL_LO: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
        result   = product[31:0];
      end
      MULH: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      MULHSU: begin
        signed_a = 1'b1;
      end
      MULHU: begin
        signed_a = 1'b0;
      end
      default: begin
        signed_a = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mul_stall_ctrl.sv
// Stall controller sequencing the multi-cycle multiplier: freezes the PC, hands
// off operands, writes the result back. Optional MUL_STALL_PERF_EN adds a stall counter.
module mul_stall_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic        is_mul,
  input  logic [1:0]  mul_op,
  input  logic [4:0]  rd_in,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic        mul_done,
  input  logic [63:0] mul_product,
  input  logic        err_clr,
  output logic        pc_en,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed_a,
  output logic        mul_signed_b,
  output logic        rf_wen_mul,
  output logic [4:0]  rf_waddr_mul,
  output logic [31:0] rf_wd_mul,
  output logic        mul_err
`ifdef MUL_STALL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  mul_ctrl_state_e  state_q, state_d;
  mul_op_e          op_q;
  logic [4:0]       rd_q;
  logic [31:0]      a_q, b_q, res_q;
  logic [CNT_W-1:0] cnt_q;

  logic        detect;
  logic        latch_ops, cnt_clr, cnt_inc, res_load, start_c, pc_en_c;
  logic        sel_signed_a, sel_signed_b;
  logic [31:0] sel_result;
  logic        in_op;

  mul_result_sel u_sel (
    .op       (op_q),
    .product  (mul_product),
    .signed_a (sel_signed_a),
    .signed_b (sel_signed_b),
    .result   (sel_result)
  );

  assign detect = instr_valid && is_mul;

  always_comb begin
    state_d   = state_q;
    pc_en_c   = 1'b0;
    start_c   = 1'b0;
    latch_ops = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    res_load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_en_c = !detect;
        if (detect) begin
          latch_ops = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start_c = 1'b1;
        cnt_clr = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done on the final timeout cycle still completes normally.
        if (mul_done) begin
          res_load = 1'b1;
          state_d  = S_WB;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_ERR;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_WB: begin
        pc_en_c = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (err_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= MUL_LO;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_ops) begin
        op_q <= mul_op_e'(mul_op);
        rd_q <= rd_in;
        a_q  <= rs1_val;
        b_q  <= rs2_val;
      end
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
      if (res_load) res_q <= sel_result;
    end
  end

  assign in_op        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_WB);
  assign pc_en        = rst && pc_en_c;
  assign mul_start    = start_c;
  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign mul_signed_a = in_op && sel_signed_a;
  assign mul_signed_b = in_op && sel_signed_b;
  assign rf_wen_mul   = (state_q == S_WB) && (rd_q != REG_ZERO);
  assign rf_waddr_mul = rd_q;
  assign rf_wd_mul    = res_q;
  assign mul_err      = (state_q == S_ERR);

`ifdef MUL_STALL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (!pc_en && ((state_q != S_IDLE) || detect) && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: doc/mul_stall_ctrl.md
Name: mul_stall_ctrl

Overview:
- Sequencing controller for the multi-cycle multiplier_32b in the single-cycle datapath.
- Detects a decoded M-extension multiply and freezes the PC by dropping pc_en.
- Issues a start/done handshake to the multiplier, then writes the selected 32-bit result to the register file and releases the PC.
- Has a stall timeout with a sticky error flag.

Parameters:
- TIMEOUT_CYCLES, 64: max WAIT cycles before error (must be ≥2).
- CNT_W, 7: width of the internal wait counter (must hold TIMEOUT_CYCLES-1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- instr_valid  in  1  current fetched instruction valid
- is_mul  in  1  decoder: instruction is MUL/MULH/MULHSU/MULHU
- mul_op  in  2  0=MUL 1=MULH 2=MULHSU 3=MULHU
- rd_in  in  5  destination register index
- rs1_val  in  32  operand A from register file
- rs2_val  in  32  operand B from register file
- mul_done  in  1  multiplier result valid (one-cycle pulse)
- mul_product  in  64  full multiplier product
- err_clr  in  1  clears sticky error, returns to IDLE
- pc_en  out  1  PC register enable
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_a  out  32  latched operand A
- mul_b  out  32  latched operand B
- mul_signed_a  out  1  treat A as signed
- mul_signed_b  out  1  treat B as signed
- rf_wen_mul  out  1  register-file write enable for the multiply result
- rf_waddr_mul  out  5  write address
- rf_wd_mul  out  32  write data
- mul_err  out  1  sticky timeout error

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all registered outputs 0.
  - pc_en=0 while rst=0.
  - Wait counter=0; mul_err=0.
  - A reset mid-operation abandons the multiply; no write-back occurs, and any later mul_done is ignored.
- States: IDLE, ISSUE, WAIT, WB, ERR.
- IDLE:
  - pc_en=1 unless instr_valid&&is_mul; in that case pc_en=0 combinationally in the same cycle.
  - On detect: latch rs1_val→mul_a, rs2_val→mul_b, mul_op, rd_in; next state ISSUE.
- ISSUE:
  - mul_start=1 for exactly one cycle; pc_en=0.
  - Clear the counter; next state WAIT.
- WAIT:
  - pc_en=0.
  - If mul_done: register the result and go to WB.
  - Else if counter==TIMEOUT_CYCLES-1: go to ERR.
  - Else increment the counter.
  - If mul_done and the timeout coincide, mul_done wins.
- WB:
  - rf_wen_mul=1 for one cycle, with rf_waddr_mul=latched rd and rf_wd_mul=result.
  - pc_en=1 so the PC advances past the multiply; next state IDLE.
  - If latched rd==0, rf_wen_mul stays 0 (no write to x0), but the PC still advances.
- ERR:
  - mul_err=1; pc_en=0; mul_done is ignored.
  - err_clr=1 → IDLE with mul_err=0 on the next edge.
- Result selection:
  - MUL → mul_product[31:0].
  - MULH, MULHSU, MULHU → mul_product[63:32].
- Signedness (held from ISSUE through WB):
  - MUL 1/1; MULH 1/1; MULHSU 1/0; MULHU 0/0.
- Out-of-state inputs:
  - mul_done outside WAIT is ignored.
  - is_mul during ISSUE/WAIT/WB is ignored; the PC is frozen, so the instruction is re-presented later.
- Minimum multiply latency, detect to PC advance: 3 cycles + multiplier latency.

Optional Feature:
- Macro: MUL_STALL_PERF_EN.
- Defined:
  - Extra output perf_stall_cycles (32-bit).
  - Increments every cycle pc_en=0 with state≠IDLE or the IDLE detect; saturates at 32'hFFFF_FFFF.
  - Reset to 0; not cleared by err_clr.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package proc_ctrl_pkg:
  - mul_op_e enum (MUL_LO, MULH, MULHSU, MULHU).
  - mul_ctrl_state_e enum.
  - Constant REG_ZERO=5'd0.
- One natural sub-module, mul_result_sel:
  - Combinational op→{signed_a, signed_b} decode and product half selection.
  - Reused by the future decode stage.

Test Plan:
- MUL 7×6, rd=5, mul_done 4 cycles after start → mul_start one pulse; pc_en low 6 cycles; rf_wen_mul=1, waddr=5, wd=42; then pc_en=1.
- MULHU 32'hFFFF_FFFF×32'h2, product 64'h1_FFFF_FFFE → wd=32'h1, signed 0/0.
- MULH with rd=0 → rf_wen_mul never asserted; PC advances after WB.
- mul_done withheld, TIMEOUT_CYCLES=8 → ERR entered after 8 WAIT cycles, mul_err=1, pc_en=0; err_clr → IDLE, pc_en=1.
- rst low during WAIT, then mul_done after release → state IDLE, no write, mul_start=0.
- mul_done on the final timeout cycle → WB, mul_err stays 0.
